// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM masters, the arbiter and the single-port RAM.
// The arbiter uses the slave modport; whatever drives the masters and the RAM uses master.
interface ram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] ram_addres;
    logic              RAM_WE;
    logic [DATA_W-1:0] data_to_mem;
    logic [DATA_W-1:0] ram_data_out;

    // Handshake: a master holds req (and addr/we/wdata) stable until a cycle
    // with req & gnt; that cycle is the transfer. Read data returns one cycle later
    // with a single-cycle rvalid pulse.
    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_addres, RAM_WE, data_to_mem,
        input  ram_data_out
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_addres, RAM_WE, data_to_mem,
        output ram_data_out
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port program/data RAM: round-robin under
// contention, optional burst lock bounded by HOLD_MAX, 1-cycle read return.
module ram_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    ram_arbiter_if.slave       bus,
    output logic [1:0]         dbg_state_o
);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;   // 1 = m1 owned the last transfer
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               gnt0_q, gnt1_q;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;

    logic               own_sel;
    logic               own_req;
    logic               own_we;
    logic               own_lock;
    logic               other_req;
    logic               xfer;
    logic [CNT_W-1:0]   hold_inc;

    function automatic state_e arb(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return last ? OWN0 : OWN1;
        else if (r0)  return OWN0;
        else if (r1)  return OWN1;
        else          return IDLE;
    endfunction

    always_comb begin
        own_sel   = (state_q == OWN1);
        own_req   = own_sel ? bus.m1_req  : bus.m0_req;
        own_we    = own_sel ? bus.m1_we   : bus.m0_we;
        own_lock  = own_sel ? bus.m1_lock : bus.m0_lock;
        other_req = own_sel ? bus.m0_req  : bus.m1_req;
        xfer      = ((state_q == OWN0) || (state_q == OWN1)) && own_req;
        hold_inc  = (hold_q == CNT_W'(HOLD_MAX)) ? hold_q : hold_q + 1'b1;

        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        rvalid0_d = xfer && !own_sel && !own_we;
        rvalid1_d = xfer &&  own_sel && !own_we;

        if ((state_q == OWN0) || (state_q == OWN1)) begin
            if (xfer) begin
                last_d = own_sel;
                // Lock is honoured freely while the other side is idle; otherwise
                // only until HOLD_MAX back-to-back transfers have been made.
                if (own_lock && (!other_req || (hold_q < CNT_W'(HOLD_MAX - 1))))
                    state_d = state_q;
                else
                    state_d = arb(bus.m0_req, bus.m1_req, own_sel);
                hold_d = (state_d == state_q) ? hold_inc : '0;
            end else begin
                // Owner withdrew its request: hand over without touching the RAM.
                state_d = arb(bus.m0_req, bus.m1_req, last_q);
                hold_d  = '0;
            end
        end else begin
            state_d = arb(bus.m0_req, bus.m1_req, last_q);
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            gnt0_q    <= (state_d == OWN0);
            gnt1_q    <= (state_d == OWN1);
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    always_comb begin
        bus.ram_addres  = '0;
        bus.RAM_WE      = 1'b0;
        bus.data_to_mem = '0;
        case (state_q)
            OWN0: begin
                bus.ram_addres  = bus.m0_addr;
                bus.RAM_WE      = bus.m0_we & bus.m0_req;
                bus.data_to_mem = bus.m0_wdata;
            end
            OWN1: begin
                bus.ram_addres  = bus.m1_addr;
                bus.RAM_WE      = bus.m1_we & bus.m1_req;
                bus.data_to_mem = bus.m1_wdata;
            end
            default: ;
        endcase
    end

    // A read whose data lands in a reset cycle is discarded.
    assign bus.m0_gnt    = gnt0_q;
    assign bus.m1_gnt    = gnt1_q;
    assign bus.m0_rvalid = rvalid0_q & ~rst;
    assign bus.m1_rvalid = rvalid1_q & ~rst;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.ram_data_out : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.ram_data_out : '0;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: per-cycle vector table plus hand sequences for lock
// limit, locked saturation and mid-read reset; read data checked via a queue.
module tb_ram_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    ram_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();

    ram_arbiter #(.ADDR_W(13), .DATA_W(32), .HOLD_MAX(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    typedef struct {
        logic        rst;
        logic        r0, w0, l0;
        logic [12:0] a0;
        logic [31:0] d0;
        logic        r1, w1, l1;
        logic [12:0] a1;
        logic [31:0] d1;
        logic        g0, g1;
    } vec_t;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [33:0] exp_q[$];
    vec_t        tbl[23];

    logic [31:0] mem     [0:8191];
    bit          mem_wr  [0:8191];
    logic [31:0] ref_mem [0:8191];
    bit          ref_wr  [0:8191];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [12:0] a);
        return (a == 13'h10) ? 32'hDEADBEEF : {3'b101, a, ~a, 3'b011};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [12:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    // Synchronous RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        bus.ram_data_out <= mem_wr[bus.ram_addres] ? mem[bus.ram_addres] : init_val(bus.ram_addres);
        if (bus.RAM_WE) begin
            mem[bus.ram_addres]    = bus.data_to_mem;
            mem_wr[bus.ram_addres] = 1'b1;
        end
    end

    function automatic vec_t mk(input logic rs,
                                input logic r0, input logic w0, input logic l0,
                                input logic [12:0] a0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic l1,
                                input logic [12:0] a1, input logic [31:0] d1,
                                input logic g0, input logic g1);
        vec_t v;
        v.rst = rs;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Drive one cycle of inputs, check that cycle's outputs, queue next-cycle read return.
    task automatic apply(input vec_t v);
        logic [33:0] e;
        logic        ev0, ev1, nv0, nv1, ewe;
        logic [12:0] ea;
        logic [31:0] ed, ewd;
        rst          = v.rst;
        bus.m0_req   = v.r0; bus.m0_we = v.w0; bus.m0_lock = v.l0;
        bus.m0_addr  = v.a0; bus.m0_wdata = v.d0;
        bus.m1_req   = v.r1; bus.m1_we = v.w1; bus.m1_lock = v.l1;
        bus.m1_addr  = v.a1; bus.m1_wdata = v.d1;
        @(negedge clk);
        e   = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        ev0 = e[33] & ~v.rst;
        ev1 = e[32] & ~v.rst;
        check("m0_rvalid", 32'(bus.m0_rvalid), 32'(ev0));
        check("m1_rvalid", 32'(bus.m1_rvalid), 32'(ev1));
        if (ev0) check("m0_rdata", bus.m0_rdata, e[31:0]);
        if (ev1) check("m1_rdata", bus.m1_rdata, e[31:0]);
        check("m0_gnt", 32'(bus.m0_gnt), 32'(v.g0));
        check("m1_gnt", 32'(bus.m1_gnt), 32'(v.g1));
        check("state", 32'(dbg_state), 32'({v.g1, v.g0}));
        ewe = (v.g0 & v.r0 & v.w0) | (v.g1 & v.r1 & v.w1);
        ea  = v.g0 ? v.a0 : (v.g1 ? v.a1 : 13'h0);
        check("RAM_WE", 32'(bus.RAM_WE), 32'(ewe));
        check("ram_addres", 32'(bus.ram_addres), 32'(ea));
        if (ewe) begin
            ewd = v.g0 ? v.d0 : v.d1;
            check("data_to_mem", bus.data_to_mem, ewd);
            ref_mem[ea] = ewd;
            ref_wr[ea]  = 1'b1;
        end
        nv0 = v.g0 & v.r0 & ~v.w0 & ~v.rst;
        nv1 = v.g1 & v.r1 & ~v.w1 & ~v.rst;
        ed  = nv0 ? ref_rd(v.a0) : (nv1 ? ref_rd(v.a1) : 32'h0);
        exp_q.push_back({nv0, nv1, ed});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both masters requesting, then round-robin reads.
        tbl[0]  = mk(1, 1,0,0,13'h20,0, 1,0,0,13'h30,0, 0,0);
        tbl[1]  = mk(0, 1,0,0,13'h20,0, 1,0,0,13'h30,0, 0,0);
        tbl[2]  = mk(0, 1,0,0,13'h20,0, 1,0,0,13'h30,0, 1,0);
        tbl[3]  = mk(0, 1,0,0,13'h20,0, 1,0,0,13'h30,0, 0,1);
        tbl[4]  = mk(0, 1,0,0,13'h20,0, 1,0,0,13'h30,0, 1,0);
        tbl[5]  = mk(0, 1,0,0,13'h20,0, 1,0,0,13'h30,0, 0,1);
        tbl[6]  = mk(0, 0,0,0,13'h20,0, 0,0,0,13'h30,0, 1,0);
        tbl[7]  = mk(0, 0,0,0,13'h0,0,  0,0,0,13'h0,0,  0,0);
        // Single m0 read of 0x0010: gnt at T1, data at T2.
        tbl[8]  = mk(0, 1,0,0,13'h10,0, 0,0,0,13'h0,0,  0,0);
        tbl[9]  = mk(0, 1,0,0,13'h10,0, 0,0,0,13'h0,0,  1,0);
        tbl[10] = mk(0, 0,0,0,13'h10,0, 0,0,0,13'h0,0,  1,0);
        tbl[11] = mk(0, 0,0,0,13'h0,0,  0,0,0,13'h0,0,  0,0);
        // m0 granted but drops req (with we=1): no write, m1 takes over.
        tbl[12] = mk(0, 1,0,0,13'h40,0, 0,0,0,13'h0,0,  0,0);
        tbl[13] = mk(0, 0,1,0,13'h40,32'h0BAD0BAD, 1,0,0,13'h50,0, 1,0);
        tbl[14] = mk(0, 0,1,0,13'h40,32'h0BAD0BAD, 1,0,0,13'h50,0, 0,1);
        tbl[15] = mk(0, 0,0,0,13'h0,0,  0,0,0,13'h50,0, 0,1);
        tbl[16] = mk(0, 0,0,0,13'h0,0,  0,0,0,13'h0,0,  0,0);
        // m1 write then m0 reads the same word back.
        tbl[17] = mk(0, 0,0,0,13'h0,0,  1,1,0,13'h60,32'h12345678, 0,0);
        tbl[18] = mk(0, 0,0,0,13'h0,0,  1,1,0,13'h60,32'h12345678, 0,1);
        tbl[19] = mk(0, 1,0,0,13'h60,0, 0,1,0,13'h60,32'h12345678, 0,1);
        tbl[20] = mk(0, 1,0,0,13'h60,0, 0,0,0,13'h0,0,  1,0);
        tbl[21] = mk(0, 0,0,0,13'h60,0, 0,0,0,13'h0,0,  1,0);
        tbl[22] = mk(0, 0,0,0,13'h0,0,  0,0,0,13'h0,0,  0,0);

        rst = 1'b1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_lock = 1'b0; bus.m0_addr = 13'h20; bus.m0_wdata = '0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = 13'h30; bus.m1_wdata = '0;
        @(posedge clk);
        #1;
        exp_q.push_back('0);

        for (int i = 0; i < 23; i++) apply(tbl[i]);

        // Locked m1 write burst against a waiting m0: exactly HOLD_MAX writes.
        apply(mk(0, 0,0,0,13'h0,0, 1,1,1,13'h100,32'hB0000000, 0,0));
        for (int k = 0; k < 8; k++)
            apply(mk(0, 1,0,0,13'h70,0, 1,1,1,13'(13'h100 + k), 32'(32'hB0000000 + k), 0,1));
        apply(mk(0, 1,0,0,13'h70,0, 1,1,1,13'h108,32'hB0000008, 1,0));
        apply(mk(0, 0,0,0,13'h0,0,  1,1,1,13'h108,32'hB0000008, 0,1));
        apply(mk(0, 0,0,0,13'h0,0,  0,0,0,13'h0,0, 0,1));
        apply(mk(0, 0,0,0,13'h0,0,  0,0,0,13'h0,0, 0,0));

        // Locked m0 reads with m1 idle run past HOLD_MAX; m1 then wins at once.
        apply(mk(0, 1,0,1,13'h100,0, 0,0,0,13'h0,0, 0,0));
        for (int i = 0; i < 10; i++)
            apply(mk(0, 1,0,1,13'(13'h100 + (i % 8)),0, (i == 9),0,0,13'h30,0, 1,0));
        apply(mk(0, 0,0,0,13'h0,0, 1,0,0,13'h30,0, 0,1));
        apply(mk(0, 0,0,0,13'h0,0, 0,0,0,13'h30,0, 0,1));
        apply(mk(0, 0,0,0,13'h0,0, 0,0,0,13'h0,0,  0,0));

        // Reset in the cycle after an m1 read transfer: data dropped, back to IDLE.
        apply(mk(0, 0,0,0,13'h0,0, 1,0,0,13'h31,0, 0,0));
        apply(mk(0, 0,0,0,13'h0,0, 1,0,0,13'h31,0, 0,1));
        apply(mk(1, 0,0,0,13'h0,0, 0,0,0,13'h0,0,  0,1));
        apply(mk(0, 0,0,0,13'h0,0, 0,0,0,13'h0,0,  0,0));
        apply(mk(0, 0,0,0,13'h0,0, 0,0,0,13'h0,0,  0,0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
